// File: rtl/sysid_stimulus_gen.sv
// LFSR excitation source and 3-tap reference FIR for LMS system identification.
// Streams (x, d) pairs in Q16.16 over valid/ready, one sample per cycle.
module sysid_stimulus_gen #(
  parameter int          NB_DATA = 32,
  parameter int          NB_CNT  = 16,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_coef_we,
  input  logic [1:0]         i_coef_addr,
  input  logic [NB_DATA-1:0] i_coef_data,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [NB_CNT-1:0]  i_num_samples,
  output logic [NB_DATA-1:0] o_x,
  output logic [NB_DATA-1:0] o_d,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_busy,
  output logic               o_done
);

  localparam int NB_PROD = 2 * NB_DATA;
  localparam int NB_SUM  = NB_PROD + 2;
  localparam int NB_FRAC = 16;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic signed [NB_DATA-1:0] r_h0, r_h1, r_h2;
  logic signed [NB_DATA-1:0] r_x, r_x1, r_x2, r_d;
  logic [15:0]               r_lfsr;
  logic [NB_CNT-1:0]         r_cnt, r_n;
  logic                      r_valid, r_done;

  logic                      w_hs, w_last, w_start;
  logic [15:0]               w_lfsr_new;
  logic signed [NB_DATA-1:0] w_xa, w_xb, w_xc, w_d;
  logic signed [NB_PROD-1:0] w_p0, w_p1, w_p2;
  logic signed [NB_SUM-1:0]  w_sum, w_sh;
  logic [NB_SUM-NB_DATA:0]   w_hi;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic signed [NB_DATA-1:0] map_x(input logic [15:0] l);
    return {{(NB_DATA-17){l[15]}}, l, 1'b0};
  endfunction

  function automatic logic signed [NB_PROD-1:0] mul(
    input logic signed [NB_DATA-1:0] a,
    input logic signed [NB_DATA-1:0] b
  );
    logic signed [NB_PROD-1:0] ea;
    logic signed [NB_PROD-1:0] eb;
    ea = NB_PROD'(a);
    eb = NB_PROD'(b);
    return ea * eb;
  endfunction

  assign w_start = (r_state == S_IDLE) & i_start;
  assign w_hs    = (r_state == S_RUN) & r_valid & i_ready & ~i_abort;
  assign w_last  = (r_cnt == r_n - NB_CNT'(1));

  // In IDLE the next sample is the first of a run: seed and empty delay line
  always_comb begin
    w_lfsr_new = lfsr_next(r_lfsr);
    w_xa       = map_x(w_lfsr_new);
    w_xb       = r_x;
    w_xc       = r_x1;
    if (r_state == S_IDLE) begin
      w_lfsr_new = SEED;
      w_xa       = map_x(SEED);
      w_xb       = '0;
      w_xc       = '0;
    end
  end

  assign w_p0  = mul(r_h0, w_xa);
  assign w_p1  = mul(r_h1, w_xb);
  assign w_p2  = mul(r_h2, w_xc);
  assign w_sum = NB_SUM'(w_p0) + NB_SUM'(w_p1) + NB_SUM'(w_p2);
  assign w_sh  = w_sum >>> NB_FRAC;
  assign w_hi  = w_sh[NB_SUM-1:NB_DATA-1];

  always_comb begin
    w_d = w_sh[NB_DATA-1:0];
    if (!((&w_hi) || (~|w_hi))) begin
      w_d = w_sh[NB_SUM-1] ? {1'b1, {(NB_DATA-1){1'b0}}}
                           : {1'b0, {(NB_DATA-1){1'b1}}};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (w_start && i_num_samples != '0) w_state_nxt = S_RUN;
      S_RUN: begin
        if (i_abort)              w_state_nxt = S_IDLE;
        else if (w_hs && w_last)  w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_h0    <= '0;
      r_h1    <= '0;
      r_h2    <= '0;
      r_lfsr  <= SEED;
      r_x     <= '0;
      r_x1    <= '0;
      r_x2    <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_n     <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      if (i_coef_we) begin
        case (i_coef_addr)
          2'd0:    r_h0 <= i_coef_data;
          2'd1:    r_h1 <= i_coef_data;
          2'd2:    r_h2 <= i_coef_data;
          default: ;
        endcase
      end
      r_done <= 1'b0;
      if (r_state == S_RUN && i_abort) begin
        r_valid <= 1'b0;
      end else if (w_start) begin
        if (i_num_samples == '0) begin
          r_done <= 1'b1;
        end else begin
          r_n     <= i_num_samples;
          r_cnt   <= '0;
          r_lfsr  <= w_lfsr_new;
          r_x     <= w_xa;
          r_x1    <= '0;
          r_x2    <= '0;
          r_d     <= w_d;
          r_valid <= 1'b1;
        end
      end else if (w_hs) begin
        if (w_last) begin
          r_valid <= 1'b0;
          r_done  <= 1'b1;
        end else begin
          r_cnt  <= r_cnt + NB_CNT'(1);
          r_x2   <= r_x1;
          r_x1   <= r_x;
          r_x    <= w_xa;
          r_lfsr <= w_lfsr_new;
          r_d    <= w_d;
        end
      end
    end
  end

  always_comb begin
    o_busy  = (r_state == S_RUN);
    o_x     = r_x;
    o_d     = r_d;
    o_valid = r_valid;
    o_done  = r_done;
  end

endmodule

// File: tb/tb_sysid_stimulus_gen.sv
// Directed-vector bench for sysid_stimulus_gen.
// Second instance uses SEED=8000 to reach the saturation corner.
module tb_sysid_stimulus_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        coef_we;
  logic [1:0]  coef_addr;
  logic [31:0] coef_data;
  logic        start;
  logic        abort;
  logic [15:0] num;
  logic        ready;

  logic [31:0] x, d, sx, sd;
  logic        valid, busy, done, svalid, sbusy, sdone;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sysid_stimulus_gen u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_coef_we(coef_we), .i_coef_addr(coef_addr), .i_coef_data(coef_data),
    .i_start(start), .i_abort(abort), .i_num_samples(num),
    .o_x(x), .o_d(d), .o_valid(valid), .i_ready(ready),
    .o_busy(busy), .o_done(done)
  );

  sysid_stimulus_gen #(.SEED(16'h8000)) u_sat (
    .i_clk(clk), .i_rst(rst),
    .i_coef_we(coef_we), .i_coef_addr(coef_addr), .i_coef_data(coef_data),
    .i_start(start), .i_abort(abort), .i_num_samples(num),
    .o_x(sx), .o_d(sd), .o_valid(svalid), .i_ready(ready),
    .o_busy(sbusy), .o_done(sdone)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h", tag, got, exp);
    end
  endtask

  task automatic wcoef(input logic [1:0] a, input logic [31:0] v);
    coef_we = 1'b1;
    coef_addr = a;
    coef_data = v;
    tick();
    coef_we = 1'b0;
  endtask

  task automatic go(input logic [15:0] n);
    num = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    start = 1'b0; abort = 1'b0; num = '0; ready = 1'b0;
    tick(); tick();
    check("rst_x", x, 32'h0);
    check("rst_d", d, 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    rst = 1'b0;

    // identity, addr 3 write must not disturb anything
    wcoef(2'd0, 32'h0001_0000);
    wcoef(2'd1, 32'h0);
    wcoef(2'd2, 32'h0);
    wcoef(2'd3, 32'h1234_5678);
    ready = 1'b1;
    go(16'd3);
    check("id_v1", 32'(valid), 32'h1);
    check("id_b1", 32'(busy), 32'h1);
    check("id_x1", x, 32'hFFFF_59C2);
    check("id_d1", d, 32'hFFFF_59C2);
    tick();
    check("id_x2", x, 32'h0000_B386);
    check("id_d2", d, 32'h0000_B386);
    tick();
    check("id_x3", x, 32'hFFFF_670E);
    check("id_d3", d, 32'hFFFF_670E);
    check("id_dn3", 32'(done), 32'h0);
    tick();
    check("id_done", 32'(done), 32'h1);
    check("id_vend", 32'(valid), 32'h0);
    check("id_bend", 32'(busy), 32'h0);
    tick();
    check("id_done_pulse", 32'(done), 32'h0);

    // delay tap
    wcoef(2'd0, 32'h0);
    wcoef(2'd1, 32'h0001_0000);
    go(16'd2);
    check("dl_d1", d, 32'h0);
    tick();
    check("dl_x2", x, 32'h0000_B386);
    check("dl_d2", d, 32'hFFFF_59C2);
    tick();
    check("dl_done", 32'(done), 32'h1);
    tick();

    // all three taps at 1.0
    wcoef(2'd0, 32'h0001_0000);
    wcoef(2'd2, 32'h0001_0000);
    go(16'd3);
    check("t3_d1", d, 32'hFFFF_59C2);
    tick();
    check("t3_d2", d, 32'h0000_0D48);
    tick();
    check("t3_d3", d, 32'hFFFF_7456);
    tick(); tick();

    // backpressure with a start pulse during the stall
    wcoef(2'd1, 32'h0);
    wcoef(2'd2, 32'h0);
    go(16'd3);
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start = (i == 1);
      num = (i == 1) ? 16'd1 : 16'd3;
      tick();
      check("bp_x", x, 32'hFFFF_59C2);
      check("bp_d", d, 32'hFFFF_59C2);
      check("bp_v", 32'(valid), 32'h1);
    end
    start = 1'b0;
    ready = 1'b1;
    tick();
    check("bp_x2", x, 32'h0000_B386);
    tick();
    check("bp_x3", x, 32'hFFFF_670E);
    check("bp_v3", 32'(valid), 32'h1);
    tick();
    check("bp_done", 32'(done), 32'h1);
    tick();

    // coefficient write coincident with a handshake
    go(16'd3);
    coef_we = 1'b1; coef_addr = 2'd0; coef_data = 32'h0002_0000;
    tick();
    coef_we = 1'b0;
    check("cw_old", d, 32'h0000_B386);
    tick();
    check("cw_new", d, 32'hFFFE_CE1C);
    tick(); tick();
    wcoef(2'd0, 32'h0001_0000);

    // abort with a same-cycle handshake, then restart
    go(16'd5);
    tick();
    check("ab_x2", x, 32'h0000_B386);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_v", 32'(valid), 32'h0);
    check("ab_b", 32'(busy), 32'h0);
    check("ab_dn", 32'(done), 32'h0);
    tick();
    check("ab_dn2", 32'(done), 32'h0);
    go(16'd1);
    check("rs_x", x, 32'hFFFF_59C2);
    check("rs_d", d, 32'hFFFF_59C2);
    tick();
    check("rs_done", 32'(done), 32'h1);
    tick();

    // zero-length run
    go(16'd0);
    check("z_done", 32'(done), 32'h1);
    check("z_v", 32'(valid), 32'h0);
    check("z_b", 32'(busy), 32'h0);
    tick();
    check("z_done2", 32'(done), 32'h0);

    // saturation corners on the SEED=8000 instance
    wcoef(2'd0, 32'h8000_0000);
    go(16'd1);
    check("sat_x", sx, 32'hFFFF_0000);
    check("sat_pos", sd, 32'h7FFF_FFFF);
    tick();
    check("sat_done", 32'(sdone), 32'h1);
    wcoef(2'd0, 32'h7FFF_FFFF);
    go(16'd1);
    check("sat_neg", sd, 32'h8000_0001);
    tick(); tick();

    // reset mid-run clears outputs and coefficients
    wcoef(2'd0, 32'h0001_0000);
    go(16'd5);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_x", x, 32'h0);
    check("mr_d", d, 32'h0);
    check("mr_v", 32'(valid), 32'h0);
    check("mr_b", 32'(busy), 32'h0);
    tick();
    check("mr_dn", 32'(done), 32'h0);
    go(16'd1);
    check("mr_x1", x, 32'hFFFF_59C2);
    check("mr_h0", d, 32'h0);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sysid_stimulus_gen.md
Name: sysid_stimulus_gen

Overview:
Stimulus and reference-channel source for the 3-tap LMS adaptive FIR (system-identification setup).
- Generates a pseudo-random excitation x[n] from a 16-bit LFSR.
- Passes x[n] through a programmable 3-tap "unknown system" FIR to produce the desired signal d[n].
- Streams (x, d) pairs to the adaptive filter over a valid/ready handshake, for a programmed number of samples.
- All data is Q16.16 signed, identical to the adaptive filter's format.

Parameters:
NB_DATA, 32, data/coefficient width (Q16.16, 16 fractional bits)
NB_CNT, 16, width of sample counter and i_num_samples
SEED, 16'hACE1, LFSR seed; must be nonzero

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, synchronous, active-high
i_coef_we  in  1  coefficient write strobe
i_coef_addr  in  2  coefficient index 0..2; 3 ignored
i_coef_data  in  NB_DATA  coefficient value, Q16.16
i_start  in  1  start a run (sampled only in IDLE)
i_abort  in  1  terminate run immediately
i_num_samples  in  NB_CNT  samples per run, latched at start
o_x  out  NB_DATA  excitation sample x[n]
o_d  out  NB_DATA  desired sample d[n]
o_valid  out  1  o_x/o_d valid
i_ready  in  1  consumer accepts the sample
o_busy  out  1  high while state != IDLE
o_done  out  1  one-cycle pulse at normal end of run

Behaviour:
Reset (i_rst=1):
- h0, h1, h2 = 0; lfsr = SEED; x1 = x2 = 0; count = 0.
- o_x = o_d = 0; o_valid = o_busy = o_done = 0; state = IDLE.

LFSR (Fibonacci):
- fb = l[15]^l[13]^l[12]^l[10]; next = {l[14:0], fb}.
- Example: ACE1 -> 59C3.

Sample mapping:
- x = {{15{l[15]}}, l, 1'b0}, i.e. the LFSR read as Q1.15 and sign-extended to Q16.16, range [-1, 1).

FIR arithmetic:
- d = h0*x + h1*x1 + h2*x2, where x1 = x[n-1] and x2 = x[n-2] relative to the sample on o_x.
- Each product is full-precision 64-bit (Q32.32); the sum is 66-bit.
- The sum is arithmetic-shifted right 16 (truncate toward -inf), then saturated to [0x80000000, 0x7FFFFFFF].

FSM states: IDLE, RUN.
- IDLE, i_start=1, i_num_samples=0: o_done pulses next cycle; no samples; stay IDLE.
- IDLE, i_start=1, i_num_samples>0:
  - Latch N; count = 0; lfsr = SEED; x1 = x2 = 0.
  - o_x = map(SEED); o_d = h0*map(SEED) (sat/trunc); o_valid = 1; go to RUN.
  - Latency: o_valid is high the cycle after i_start.
- RUN, handshake (o_valid & i_ready):
  - If count == N-1: o_valid = 0, o_done = 1 for one cycle, go to IDLE.
  - Else:
    - count++; x2 = x1; x1 = o_x; lfsr = next(lfsr).
    - o_x = map(next).
    - o_d = h0*map(next) + h1*o_x + h2*x1, using old register values.
    - o_valid stays 1. Throughput is one sample per cycle; there are no bubbles.
- RUN, no handshake: o_x, o_d, o_valid held stable. o_valid never drops without a handshake, except on abort or reset.
- i_abort=1 in RUN: o_valid = 0, IDLE next cycle, no o_done. i_abort has priority over a same-cycle handshake.
- i_start in RUN is ignored.

Coefficient writes:
- Accepted in any state; the register updates at the clock edge.
- A sample computed in the same cycle as a write uses the pre-write coefficient.
- Writes take effect on the next computed sample; o_d already presented is not recomputed.
- Address 3 is a no-op.

Reset mid-run: reset wins over everything; all outputs go to their reset values the next cycle and no o_done is issued.

Test Plan:
- Identity: write h0=0x00010000, h1=h2=0; start N=3, i_ready=1 -> (o_x, o_d) = (FFFF59C2, FFFF59C2), (0000B386, 0000B386), then the third sample per LFSR; o_done pulses once after the third handshake; o_busy falls with it.
- Delay tap: h1=0x00010000, h0=h2=0; N=2 -> first o_d=0; second o_x=0000B386, o_d=FFFF59C2.
- Saturation: SEED=16'h8000, h0=0x80000000, h1=h2=0; N=1 -> o_x=FFFF0000, o_d=7FFFFFFF. Also h0=0x7FFFFFFF with SEED=16'h8000 -> o_d=80000001 (−h0 truncated, in range).
- Backpressure: N=3, i_ready low 3 cycles after the first valid -> o_x/o_d/o_valid constant through the stall; the sequence resumes identical to the no-stall run; exactly 3 handshakes total.
- Abort and restart: abort after 1 handshake of N=5 -> o_valid=0 next cycle, no o_done. Restart N=1 -> o_x=FFFF59C2 again (LFSR reseeded, x1=x2 cleared).
- Edge cases:
  - start with N=0 -> o_done pulse, o_valid never high.
  - coef write to h0 in the same cycle as a handshake -> the new sample uses the old h0; the following sample uses the new h0.
  - i_start during RUN -> ignored.
  - i_rst mid-run -> all outputs 0 next cycle.
